// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package ifetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Circular buffer of fetched {pc, instr} pairs; flush empties it in one cycle.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  fetch_entry_t     mem [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) mem[tail] <= wdata;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = empty ? '0 : mem[head];

endmodule

// File: rtl/ifetch_unit.sv
// Fetch PC, redirect handling and decode handshake around ifetch_fifo.
// IFETCH_BYPASS_EN: an empty queue forwards the current fetch word combinationally.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc;
  fetch_entry_t     head_entry;
  fetch_entry_t     new_entry;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             bypass;
  logic             pop;
  logic             push;
  logic             fifo_push;
  logic             fifo_pop;

  assign imem_addr = fetch_pc;
  assign new_entry = '{pc: fetch_pc, instr: imem_instr};

  // Handshake and queue control; a bypassed word is consumed without enqueueing.
  always_comb begin
    bypass = 1'b0;
`ifdef IFETCH_BYPASS_EN
    bypass = empty & ~redirect_valid;
`endif
    out_valid = (count != '0) | bypass;
    out_pc    = bypass ? fetch_pc   : head_entry.pc;
    out_instr = bypass ? imem_instr : head_entry.instr;
    pop       = out_valid & out_ready;
    push      = ~redirect_valid & (~full | pop);
    fifo_pop  = pop & ~bypass;
    fifo_push = push & ~(bypass & pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= align_word(redirect_pc);
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'(WORD_BYTES);
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .wdata (new_entry),
    .rdata (head_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: queue-level reference model plus literal checkpoints.
module tb_ifetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory contents: word n holds n+1.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {2'b00, a[31:2]} + 32'd1;
  endfunction

  assign imem_instr = word_of(imem_addr);

  always #5 clk = ~clk;

  ifetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending PCs and the next PC to fetch.
  logic [31:0] mq[$];
  logic [31:0] mpc;
  bit          started = 1'b0;
  bit          m_v, m_p, m_had;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mpc = RESET_PC;
      started = 1'b1;
    end else if (started) begin
      m_had = (mq.size() != 0);
      m_v   = m_had || (BYP && !redirect_valid);
      m_p   = m_v && out_ready;
      if (redirect_valid) begin
        mq.delete();
        mpc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (m_p && m_had) void'(mq.pop_front());
        if (mq.size() < DEPTH) begin
          if (!(m_p && !m_had)) mq.push_back(mpc);
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  // PCs actually handed to decode by the DUT.
  logic [31:0] seen[$];
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) seen.push_back(out_pc);
  end

  logic        e_v;
  logic [31:0] e_pc;
  always @(negedge clk) begin
    if (started) begin
      e_v  = (mq.size() != 0) || (BYP && !redirect_valid);
      e_pc = (mq.size() != 0) ? mq[0] : (e_v ? mpc : 32'h0);
      check("model imem_addr", imem_addr, mpc);
      check("model out_valid", {31'b0, out_valid}, {31'b0, e_v});
      check("model out_pc", out_pc, e_pc);
      check("model out_instr", out_instr, e_v ? word_of(e_pc) : 32'h0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_seen(input string name, input logic [31:0] exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      check(name, (i < seen.size()) ? seen[i] : 32'hBAD0_BAD0, exp[i]);
    end
  endtask

  logic [31:0] e[$];
  logic [23:0] rdy_pat;
  logic [23:0] rdr_pat;

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    tick(1);

    // Streaming after reset with decode always ready.
    rst_n = 1'b1; seen.delete();
    tick(1);
    check("t1 out_valid", {31'b0, out_valid}, 32'd1);
    check("t1 out_pc", out_pc, BYP ? 32'h4 : 32'h0);
    check("t1 out_instr", out_instr, BYP ? 32'h2 : 32'h1);
    tick(4);
    e = '{32'h0, 32'h4, 32'h8, 32'hC};
    check_seen("t1 stream", e);

    // Decode stalled: queue saturates, fetch PC holds.
    rst_n = 1'b0; out_ready = 1'b0; tick(1);
    rst_n = 1'b1; tick(5);
    check("t2 held pc", imem_addr, 32'h8);
    check("t2 out_pc", out_pc, 32'h0);
    out_ready = 1'b1; seen.delete(); tick(3);
    e = '{32'h0, 32'h4, 32'h8};
    check_seen("t2 drain", e);

    // Redirect discards queued 4 and 8.
    rst_n = 1'b0; out_ready = 1'b0; tick(1);
    rst_n = 1'b1; tick(2);
    out_ready = 1'b1; tick(1);
    check("t3 head", out_pc, 32'h4);
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0023; tick(1);
    check("t3 imem_addr", imem_addr, 32'h20);
    check("t3 out_valid", {31'b0, out_valid}, 32'd0);
    redirect_valid = 1'b0; out_ready = 1'b1; seen.delete(); tick(2);
    e = '{32'h20};
    check_seen("t3 target", e);

    // Pop coincident with redirect counts as delivered.
    rst_n = 1'b0; out_ready = 1'b0; tick(1);
    rst_n = 1'b1; tick(1);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; seen.delete(); tick(1);
    check("t4 out_valid", {31'b0, out_valid}, 32'd0);
    check("t4 imem_addr", imem_addr, 32'h40);
    redirect_valid = 1'b0; tick(2);
    e = '{32'h0, 32'h40};
    check_seen("t4 seq", e);

    // PC wraps at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; tick(1);
    redirect_valid = 1'b0; seen.delete(); tick(4);
    e = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    check_seen("t5 wrap", e);

    // Reset beats a redirect with a full queue.
    out_ready = 1'b0; tick(3);
    check("t6 full valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80; out_ready = 1'b1; tick(1);
    check("t6 rst out_valid", {31'b0, out_valid}, 32'd0);
    check("t6 rst imem_addr", imem_addr, RESET_PC);
    rst_n = 1'b1; redirect_valid = 1'b0; #1;
    check("t6 release valid", {31'b0, out_valid}, BYP ? 32'd1 : 32'd0);
    tick(1);
    check("t6 first pc", out_pc, BYP ? 32'h4 : 32'h0);

    // Mixed stall/redirect pattern against the model.
    rdy_pat = 24'b1011_0011_1101_0110_0111_1001;
    rdr_pat = 24'b0000_1000_0001_1000_0100_0010;
    for (int i = 0; i < 24; i++) begin
      out_ready      = rdy_pat[i];
      redirect_valid = rdr_pat[i];
      redirect_pc    = 32'h1000 + 32'(i * 7);
      tick(1);
    end
    redirect_valid = 1'b0; out_ready = 1'b1; tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
